// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encodings, default timing constants
// and the odd-parity helper used by both the transmitter and the receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAITIDLE = 3'd5
    } ps2_state_e;

    // Defaults assume a 50 MHz system clock.
    localparam int PS2_INHIBIT_CYCLES = 5000;     // 100 us clock inhibit
    localparam int PS2_REQ_CYCLES     = 100;      // request-to-send hold
    localparam int PS2_TIMEOUT_CYCLES = 1000000;  // 20 ms transfer watchdog
    localparam int PS2_FILTER_CYCLES  = 8;        // line debounce length
    localparam int PS2_CNT_W          = 20;       // shared phase/timeout counter

    // Odd parity: returns the bit that makes the total number of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILTER_CYCLES debounce and a
// one-cycle pulse when the debounced level falls from 1 to 0.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES = PS2_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst,      // asynchronous, active-low
    input  logic i_raw,
    output logic o_level,
    output logic o_fall
);

    localparam int                CW     = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0]     C_LAST = CW'(FILTER_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_fall;

    // Bring the raw pin into the clk domain; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Accept a new level only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                    r_fall  <= r_level;   // old level 1 -> new level 0
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out
// 8 data bits + odd parity + stop on device clocks, then sample the ACK.
// Lines are open-drain; the Oe outputs only ever pull a line low.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int REQ_CYCLES     = PS2_REQ_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_CYCLES  = PS2_FILTER_CYCLES
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic       ackOk,
    output logic       error,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe
);

    localparam logic [PS2_CNT_W-1:0] C_INH_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] C_REQ_LAST = PS2_CNT_W'(REQ_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] C_TO_LAST  = PS2_CNT_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall_unused;

    ps2_state_e           r_state;
    logic [PS2_CNT_W-1:0] r_cnt;
    logic [3:0]           r_bit_idx;
    logic [7:0]           r_data;
    logic                 r_parity;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ack_ok;
    logic                 r_error;
    logic                 r_clk_oe;
    logic                 r_data_oe;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (ps2ClkIn),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (ps2DataIn),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall_unused)
    );

    // Transfer sequencer; one counter times the inhibit/request phases and
    // doubles as the watchdog once the clock has been handed to the device.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (txStart) begin
                        r_data   <= txData;
                        r_parity <= odd_parity(txData);
                        r_busy   <= 1'b1;
                        r_ack_ok <= 1'b0;
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_cnt == C_INH_LAST) begin
                        r_cnt     <= '0;
                        r_data_oe <= 1'b1;        // start bit
                        r_state   <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    if (r_cnt == C_REQ_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_clk_oe  <= 1'b0;        // hand the clock to the device
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT, ST_ACK, ST_WAITIDLE: begin
                    if (r_cnt == C_TO_LAST) begin
                        r_cnt     <= '0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_error   <= 1'b1;
                        r_ack_ok  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_state == ST_SHIFT && w_clk_fall) begin
                            // Data only changes while the device holds clock low.
                            r_bit_idx <= r_bit_idx + 1'b1;
                            if (r_bit_idx < 4'd8) begin
                                r_data_oe <= ~r_data[r_bit_idx[2:0]];
                            end else if (r_bit_idx == 4'd8) begin
                                r_data_oe <= ~r_parity;
                            end else begin
                                r_data_oe <= 1'b0;        // stop bit: release
                                r_cnt     <= '0;
                                r_state   <= ST_ACK;
                            end
                        end
                        if (r_state == ST_ACK && w_clk_fall) begin
                            r_ack_ok <= ~w_data_lvl;
                            r_cnt    <= '0;
                            r_state  <= ST_WAITIDLE;
                        end
                        if (r_state == ST_WAITIDLE && w_clk_lvl && w_data_lvl) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign ackOk     = r_ack_ok;
    assign error     = r_error;
    assign ps2ClkOe  = r_clk_oe;
    assign ps2DataOe = r_data_oe;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the DUT,
// randomized bytes are compared against frames built from the byte alone.
module tb_ps2_tx;

    localparam int INH  = 60;
    localparam int REQ  = 12;
    localparam int TO   = 3000;
    localparam int FILT = 4;
    localparam int HP   = 50;     // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txStart = 1'b0;
    logic       busy, done, ackOk, error;
    logic       ps2ClkOe, ps2DataOe;
    logic       ps2ClkIn, ps2DataIn;

    logic bfm_clk_low  = 1'b0;
    logic bfm_data_low = 1'b0;
    logic glitch       = 1'b0;
    logic clk_line, data_line;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    assign clk_line  = ~(ps2ClkOe | bfm_clk_low);
    assign data_line = ~(ps2DataOe | bfm_data_low);
    assign ps2ClkIn  = clk_line & ~glitch;
    assign ps2DataIn = data_line;

    ps2_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TO),
        .FILTER_CYCLES  (FILT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .txData    (txData),
        .txStart   (txStart),
        .busy      (busy),
        .done      (done),
        .ackOk     (ackOk),
        .error     (error),
        .ps2ClkIn  (ps2ClkIn),
        .ps2DataIn (ps2DataIn),
        .ps2ClkOe  (ps2ClkOe),
        .ps2DataOe (ps2DataOe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones;
        logic [10:0] f;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device model: waits for request-to-send, issues clock pulses, samples
    // data just before each rising edge, optionally ACKs on the 11th pulse.
    task automatic bfm_rx(input int npulses, input bit ack_low, input bit glitch_en,
                          output logic [10:0] frame);
        int t;
        int n;
        frame = '1;
        t = 0;
        while (!(clk_line && !data_line) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("bfm_request_seen", (t < 1000), 1);
        frame[0] = data_line;
        n = (npulses > 10) ? 10 : npulses;
        for (int i = 1; i <= n; i++) begin
            repeat (HP / 2) @(negedge clk);
            if (glitch_en && i == 4) glitch = 1'b1;
            repeat (3) @(negedge clk);
            glitch = 1'b0;
            repeat (HP / 2 - 3) @(negedge clk);
            bfm_clk_low = 1'b1;
            repeat (HP) @(negedge clk);
            frame[i] = data_line;
            bfm_clk_low = 1'b0;
        end
        if (npulses >= 11) begin
            repeat (HP / 2) @(negedge clk);
            if (ack_low) bfm_data_low = 1'b1;
            repeat (HP / 2) @(negedge clk);
            bfm_clk_low = 1'b1;
            repeat (HP) @(negedge clk);
            bfm_clk_low  = 1'b0;
            bfm_data_low = 1'b0;
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        txData  = b;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit ack_low, input bit stray,
                        input bit glitch_en);
        int n1;
        int n2;
        int t;
        logic [10:0] frame;
        start_tx(b);
        check("busy_set", busy, 1);
        check("ackok_cleared", ackOk, 0);
        n1 = 0;
        while (ps2ClkOe && !ps2DataOe && n1 < INH + 20) begin
            if (stray && n1 == 2) begin
                txData  = 8'h55;
                txStart = 1'b1;
            end
            if (stray && n1 == 3) begin
                txStart = 1'b0;
                txData  = b;
            end
            @(negedge clk);
            n1++;
        end
        txStart = 1'b0;
        n2 = 0;
        while (ps2ClkOe && ps2DataOe && n2 < REQ + 20) begin
            @(negedge clk);
            n2++;
        end
        check("inhibit_len", n1, INH);
        check("req_len", n2, REQ);
        bfm_rx(11, ack_low, glitch_en, frame);
        check("frame", frame, exp_frame(b));
        t = 0;
        while (!done && !error && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done", done, 1);
        check("ackok", ackOk, ack_low);
        check("no_error", error, 0);
        check("busy_drop", busy, 0);
    endtask

    initial begin
        int t;
        int c0;
        logic [10:0] f;
        logic [7:0] rb;
        bit ra;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ackok", ackOk, 0);
        check("rst_error", error, 0);
        check("rst_clkoe", ps2ClkOe, 0);
        check("rst_dataoe", ps2DataOe, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // LED-set command with ACK
        send(8'hED, 1'b1, 1'b0, 1'b0);
        // Back-to-back, next start on the cycle after done
        send(8'h01, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        // Device does not ACK
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        // txStart while busy is ignored
        send(8'hED, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        // Short glitch on the clock pin must not advance the bit index
        send(8'h3C, 1'b1, 1'b0, 1'b1);
        // Randomized bytes and ACK behaviour
        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            repeat (3) @(negedge clk);
            send(rb, ra, 1'b0, (k == 2));
        end

        // Device never clocks: watchdog abort
        repeat (5) @(negedge clk);
        start_tx(8'h3C);
        t = 0;
        while (ps2ClkOe && t < INH + REQ + 20) begin
            @(negedge clk);
            t++;
        end
        check("to_clk_released", ps2ClkOe, 0);
        c0 = cyc;
        t = 0;
        while (!error && t < TO + 50) begin
            @(negedge clk);
            t++;
        end
        check("to_error", error, 1);
        check("to_latency", cyc - c0, TO);
        check("to_clkoe", ps2ClkOe, 0);
        check("to_dataoe", ps2DataOe, 0);
        check("to_busy", busy, 0);
        check("to_no_done", done, 0);
        check("to_ackok", ackOk, 0);
        @(negedge clk);
        check("to_error_pulse", error, 0);

        // Reset mid-transfer after the 4th device clock pulse
        repeat (5) @(negedge clk);
        start_tx(8'hED);
        t = 0;
        while (ps2ClkOe && t < INH + REQ + 20) begin
            @(negedge clk);
            t++;
        end
        bfm_rx(4, 1'b0, 1'b0, f);
        check("mid_busy", busy, 1);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_clkoe", ps2ClkOe, 0);
        check("mid_rst_dataoe", ps2DataOe, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
